// File: rtl/pipe_ctrl_if.sv
// Hazard/stall control bundle between the pipeline stages and pipe_ctrl.
// master = pipeline side driving hazard inputs, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic [4:0] ex_rd_i;
  logic       ex_memread_i;
  logic       ex_branch_taken_i;
  logic       ex_mdu_start_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       if_pause_o;
  logic       if_flush_o;
  logic       id_pause_o;
  logic       id_flush_o;
  logic       ex_pause_o;
  logic       mem_bubble_o;
  logic       mdu_done_o;
  logic       busy_o;
  logic       err_o;

  modport master (
    output id_rs1_i, id_rs2_i, ex_rd_i, ex_memread_i, ex_branch_taken_i,
           ex_mdu_start_i, mem_req_i, mem_ack_i,
    input  if_pause_o, if_flush_o, id_pause_o, id_flush_o, ex_pause_o,
           mem_bubble_o, mdu_done_o, busy_o, err_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, ex_rd_i, ex_memread_i, ex_branch_taken_i,
           ex_mdu_start_i, mem_req_i, mem_ack_i,
    output if_pause_o, if_flush_o, id_pause_o, id_flush_o, ex_pause_o,
           mem_bubble_o, mdu_done_o, busy_o, err_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory stalls, multi-cycle MDU, branch and load-use.
// Optional memory-ack timeout with sticky error: define PIPE_CTRL_MEM_TIMEOUT_EN.
module pipe_ctrl #(
  parameter int unsigned MDU_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pipe_ctrl_if.slave  ctl
);

  if (MDU_CYCLES < 2 || MDU_CYCLES > 255) begin : g_bad_mdu
    $error("pipe_ctrl: MDU_CYCLES out of range 2..255");
  end
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 1023) begin : g_bad_tmo
    $error("pipe_ctrl: MEM_TIMEOUT out of range 1..1023");
  end

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MDU     = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 2);

  state_e     state_q, state_d;
  logic [7:0] mdu_cnt_q, mdu_cnt_d;

  logic if_pause, if_flush, id_pause, id_flush, ex_pause, bubble, done;
  logic mem_stall, load_use;

  assign mem_stall = ctl.mem_req_i & ~ctl.mem_ack_i;
  assign load_use  = ctl.ex_memread_i && (ctl.ex_rd_i != 5'd0) &&
                     ((ctl.ex_rd_i == ctl.id_rs1_i) || (ctl.ex_rd_i == ctl.id_rs2_i));

`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(MEM_TIMEOUT - 1);
  logic [9:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    if_pause  = 1'b0;
    if_flush  = 1'b0;
    id_pause  = 1'b0;
    id_flush  = 1'b0;
    ex_pause  = 1'b0;
    bubble    = 1'b0;
    done      = 1'b0;
`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          {if_pause, id_pause, ex_pause} = 3'b111;
          state_d = MEMWAIT;
        end else if (ctl.ex_mdu_start_i) begin
          {if_pause, id_pause, ex_pause, bubble} = 4'b1111;
          mdu_cnt_d = MDU_LOAD;
          state_d   = MDU;
        end else if (ctl.ex_branch_taken_i) begin
          // a taken branch squashes the dependent instruction anyway
          {if_flush, id_flush} = 2'b11;
        end else if (load_use) begin
          {if_pause, id_flush} = 2'b11;
        end
      end
      MDU: begin
        {if_pause, id_pause, ex_pause, bubble} = 4'b1111;
        if (mdu_cnt_q == 8'd0) begin
          done    = 1'b1;
          state_d = RUN;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 8'd1;
        end
      end
      MEMWAIT: begin
        if (ctl.mem_ack_i) begin
          state_d = RUN;
`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // give up on the access: release the pipe and flag it
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = RUN;
        end else begin
          {if_pause, id_pause, ex_pause} = 3'b111;
          tmo_d = tmo_q + 10'd1;
        end
`else
        end else begin
          {if_pause, id_pause, ex_pause} = 3'b111;
        end
`endif
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign ctl.err_o = err_q & ~rst_i;
`else
  assign ctl.err_o = 1'b0;
`endif

  // reset forces every output low regardless of state or inputs
  assign ctl.if_pause_o   = if_pause & ~rst_i;
  assign ctl.if_flush_o   = if_flush & ~rst_i;
  assign ctl.id_pause_o   = id_pause & ~rst_i;
  assign ctl.id_flush_o   = id_flush & ~rst_i;
  assign ctl.ex_pause_o   = ex_pause & ~rst_i;
  assign ctl.mem_bubble_o = bubble   & ~rst_i;
  assign ctl.mdu_done_o   = done     & ~rst_i;
  assign ctl.busy_o       = (state_q != RUN) & ~rst_i;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MDU_CYCLES, default 32, total stall cycles for one multi-cycle MDU operation, including the start cycle; legal range 2..255.
REQ-002 Parameter MEM_TIMEOUT, default 255, number of MEMWAIT cycles without ack before an error is raised; used only with PIPE_CTRL_MEM_TIMEOUT_EN; legal range 1..1023.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 id_rs1_i  input  5  rs1 of the instruction in ID.
REQ-006 id_rs2_i  input  5  rs2 of the instruction in ID.
REQ-007 ex_rd_i  input  5  rd of the instruction in EX.
REQ-008 ex_memread_i  input  1  instruction in EX is a load.
REQ-009 ex_branch_taken_i  input  1  branch or jump in EX redirects the PC.
REQ-010 ex_mdu_start_i  input  1  instruction in EX is a multi-cycle MDU operation.
REQ-011 mem_req_i  input  1  instruction in MEM issues a data-memory access.
REQ-012 mem_ack_i  input  1  data memory completes the access this cycle.
REQ-013 if_pause_o, if_flush_o  output  1 each  pause and flush for the PC and IF/ID register.
REQ-014 id_pause_o, id_flush_o  output  1 each  pause and flush for the ID/EX register.
REQ-015 ex_pause_o  output  1  hold the EX/MEM register.
REQ-016 mem_bubble_o  output  1  insert a bubble into the EX/MEM register.
REQ-017 mdu_done_o  output  1  one-cycle pulse in the last MDU stall cycle.
REQ-018 busy_o  output  1  state is not RUN.
REQ-019 err_o  output  1  sticky memory-timeout error.

Function
REQ-020 The FSM SHALL have states RUN, MDU and MEMWAIT; outputs SHALL be combinational decodes of the registered state and the current inputs.
REQ-021 In RUN the conditions SHALL be evaluated in this priority order: memory stall > MDU start > branch > load-use; only the highest active condition acts.
REQ-022 Memory stall: mem_req_i=1 and mem_ack_i=0 in RUN SHALL assert if_pause_o, id_pause_o and ex_pause_o in that cycle, and the next state SHALL be MEMWAIT; mem_req_i=1 with mem_ack_i=1 SHALL cause no stall.
REQ-023 In MEMWAIT, all three pauses SHALL stay asserted until a cycle with mem_ack_i=1; in that cycle the pauses SHALL be deasserted and the next state SHALL be RUN.
REQ-024 MDU start in RUN SHALL assert the three pauses and mem_bubble_o, load the counter with MDU_CYCLES-2, and enter MDU.
REQ-025 In MDU the same four outputs SHALL stay asserted and the counter SHALL decrement each cycle; at counter 0, mdu_done_o=1 and the next state SHALL be RUN, giving exactly MDU_CYCLES stalled cycles.
REQ-026 Branch in RUN SHALL assert if_flush_o and id_flush_o for one cycle with no state change, and SHALL suppress any load-use stall in that cycle.
REQ-027 Load-use in RUN SHALL assert if_pause_o and id_flush_o for one cycle.
REQ-028 Load-use SHALL be detected when ex_memread_i=1, ex_rd_i!=0, and ex_rd_i equals id_rs1_i or id_rs2_i.
REQ-029 While in MDU or MEMWAIT, branch, load-use and new MDU starts SHALL be ignored; these are held by the pauses and re-evaluated on return to RUN.
REQ-030 A pause output and the flush output of the same stage SHALL never be asserted together.
REQ-031 busy_o SHALL equal 1 exactly when the state is MDU or MEMWAIT.

Reset
REQ-032 While rst_i=1, all outputs SHALL be 0, and on the clock edge the state SHALL become RUN, all counters 0 and err_o 0.
REQ-033 Reset asserted mid-MDU or mid-MEMWAIT SHALL abort the operation with no mdu_done_o pulse.

Configuration
REQ-034 With PIPE_CTRL_MEM_TIMEOUT_EN defined, a MEMWAIT cycle counter SHALL count each MEMWAIT cycle without ack.
REQ-035 With PIPE_CTRL_MEM_TIMEOUT_EN defined, when that counter reaches MEM_TIMEOUT, err_o SHALL set (sticky until reset), the pauses SHALL drop that cycle and the next state SHALL be RUN.
REQ-036 Without PIPE_CTRL_MEM_TIMEOUT_EN, err_o SHALL be tied 0, MEMWAIT SHALL be unbounded and no timeout counter SHALL exist.

Verification
REQ-037 Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 -> if_pause_o=1 and id_flush_o=1 for exactly one cycle; with ex_rd_i=0 -> no stall.
REQ-038 MDU: MDU_CYCLES=4, ex_mdu_start_i pulse -> pauses high for 4 cycles, mdu_done_o high only in the 4th cycle, busy_o high for cycles 2-4.
REQ-039 Memory: mem_req_i=1 with ack after 3 cycles -> pauses high for 3 cycles, low in the ack cycle, then state RUN.
REQ-040 Priority: mem stall, branch and load-use asserted together -> only pauses asserted, flushes 0; after ack, branch holds -> if_flush_o=1 and id_flush_o=1 for one cycle.
REQ-041 Reset mid-MDU: rst_i at MDU cycle 2 -> all outputs 0, state RUN, no mdu_done_o pulse.
REQ-042 Timeout (macro on, MEM_TIMEOUT=8): mem_req_i held with no ack -> err_o=1 after 8 cycles, pauses released, err_o stays 1 until rst_i.
